// File: rtl/alu_mul_seq_if.sv
// alu_mul_seq_if: multiply request/result handshake plus shared-ALU borrow bus
// start/op_a/op_b   : request and 16-bit unsigned operands
// busy/done         : activity flag and one-cycle completion pulse
// result/ovf        : low 16 product bits and product >= 2^16 flag
// alu_req/alu_op1/alu_op2/alu_cmd : block drives the shared ALU while alu_req=1
// alu_res/alu_ovf   : combinational ALU result and adder carry-out
interface alu_mul_seq_if;
  logic        start;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        ovf;
  logic        alu_req;
  logic [15:0] alu_op1;
  logic [15:0] alu_op2;
  logic [2:0]  alu_cmd;
  logic [15:0] alu_res;
  logic        alu_ovf;
  modport master (
    output start, op_a, op_b, alu_res, alu_ovf,
    input  busy, done, result, ovf, alu_req, alu_op1, alu_op2, alu_cmd
  );
  modport slave (
    input  start, op_a, op_b, alu_res, alu_ovf,
    output busy, done, result, ovf, alu_req, alu_op1, alu_op2, alu_cmd
  );
endinterface

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-add 16x16 multiplier that borrows a shared ALU for adds and shifts
// clk/rst : clock and asynchronous active-high reset
// bus     : alu_mul_seq_if.slave (request, result and shared-ALU signals)
module alu_mul_seq (
  input logic clk,
  input logic rst,
  alu_mul_seq_if.slave bus
);
  typedef enum logic [2:0] {IDLE, EVAL, ADD, SHIFT, DONE} state_t;
  state_t      r_state, w_next;
  logic [15:0] r_mcand, r_mplier, r_acc, r_result;
  logic        r_ovf_s, r_ovf;
  assign bus.busy   = r_state != IDLE;
  assign bus.done   = r_state == DONE;
  assign bus.result = r_result;
  assign bus.ovf    = r_ovf;
  always_comb begin
    w_next      = r_state;
    bus.alu_req = 1'b0;
    bus.alu_op1 = 16'd0;
    bus.alu_op2 = 16'd0;
    bus.alu_cmd = 3'b000;
    case (r_state)
      IDLE:  w_next = bus.start ? EVAL : IDLE;
      EVAL:  w_next = r_mplier == 16'd0 ? DONE : r_mplier[0] ? ADD : SHIFT;
      ADD: begin
        bus.alu_req = 1'b1;
        bus.alu_op1 = r_acc;
        bus.alu_op2 = r_mcand;
        w_next      = SHIFT;
      end
      SHIFT: begin
        bus.alu_req = 1'b1;
        bus.alu_op1 = r_mcand;
        bus.alu_op2 = 16'd1;
        bus.alu_cmd = 3'b010;
        w_next      = EVAL;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_mcand  <= 16'd0;
      r_mplier <= 16'd0;
      r_acc    <= 16'd0;
      r_ovf_s  <= 1'b0;
      r_result <= 16'd0;
      r_ovf    <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (bus.start) begin
          r_mcand  <= bus.op_a;
          r_mplier <= bus.op_b;
          r_acc    <= 16'd0;
          r_ovf_s  <= 1'b0;
        end
        ADD: begin
          r_acc   <= bus.alu_res;
          r_ovf_s <= r_ovf_s | bus.alu_ovf;
        end
        SHIFT: begin
          r_mcand  <= bus.alu_res;
          r_mplier <= r_mplier >> 1;
          // a set bit leaving mcand only matters if a later multiplier bit would add it
          if (r_mcand[15] && |r_mplier[15:1]) r_ovf_s <= 1'b1;
        end
        DONE: begin
          r_result <= r_acc;
          r_ovf    <= r_ovf_s;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: directed and random checks of alu_mul_seq against an arithmetic reference
module tb_alu_mul_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   passed = 0;
  alu_mul_seq_if bus();
  alu_mul_seq dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  logic [16:0] sum17;
  assign sum17       = {1'b0, bus.alu_op1} + {1'b0, bus.alu_op2};
  assign bus.alu_res = bus.alu_cmd == 3'b000 ? sum17[15:0] :
                       bus.alu_cmd == 3'b010 ? bus.alu_op1 << bus.alu_op2 :
                       bus.alu_cmd == 3'b100 ? bus.alu_op1 >> bus.alu_op2 : 16'd0;
  assign bus.alu_ovf = bus.alu_cmd == 3'b000 ? sum17[16] : 1'b0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  function automatic int exp_lat(input logic [15:0] b);
    int c = 2;
    for (int i = 0; i < 16; i++) if ((b >> i) != 16'd0) c += b[i] ? 3 : 2;
    return c;
  endfunction
  function automatic int exp_reqs(input logic [15:0] b);
    int c = 0;
    for (int i = 0; i < 16; i++) if ((b >> i) != 16'd0) c += b[i] ? 2 : 1;
    return c;
  endfunction
  task automatic run(input logic [15:0] a, input logic [15:0] b, output int lat, output int reqs);
    @(negedge clk);
    bus.op_a  = a;
    bus.op_b  = b;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat  = 1;
    reqs = int'(bus.alu_req);
    while (!bus.done && lat < 100) begin
      @(negedge clk);
      lat++;
      reqs += int'(bus.alu_req);
    end
  endtask
  task automatic check_op(input string tag, input logic [15:0] a, input logic [15:0] b);
    int lat, reqs;
    logic [31:0] p;
    p = {16'd0, a} * {16'd0, b};
    run(a, b, lat, reqs);
    chk({tag, "_lat"}, lat, exp_lat(b));
    chk({tag, "_reqs"}, reqs, exp_reqs(b));
    @(negedge clk);
    chk({tag, "_res"}, {16'd0, bus.result}, {16'd0, p[15:0]});
    chk({tag, "_ovf"}, {31'd0, bus.ovf}, {31'd0, p >= 32'h10000});
    chk({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
  endtask
  initial begin
    int lat, reqs, n;
    logic [15:0] a, b;
    bus.start = 1'b0;
    bus.op_a  = 16'd0;
    bus.op_b  = 16'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_req", {31'd0, bus.alu_req}, 32'd0);
    chk("rst_ops", {bus.alu_op1, bus.alu_op2}, 32'd0);
    chk("rst_cmd", {29'd0, bus.alu_cmd}, 32'd0);
    chk("rst_res", {15'd0, bus.ovf, bus.result}, 32'd0);
    rst = 1'b0;
    check_op("m3x5", 16'd3, 16'd5);
    check_op("mffffx1", 16'hFFFF, 16'd1);
    check_op("m100x100", 16'h0100, 16'h0100);
    check_op("m8000x2", 16'h8000, 16'd2);
    check_op("m1234x0", 16'h1234, 16'd0);
    check_op("m1xffff", 16'd1, 16'hFFFF);
    check_op("mffffxffff", 16'hFFFF, 16'hFFFF);
    check_op("m8000x1", 16'h8000, 16'd1);
    @(negedge clk);
    bus.op_a  = 16'hFFFF;
    bus.op_b  = 16'd1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("seq_eval_req", {31'd0, bus.alu_req}, 32'd0);
    @(negedge clk);
    chk("seq_add", {bus.alu_req, bus.alu_cmd, bus.alu_op2}, {13'd0, 1'b1, 3'b000, 16'hFFFF});
    @(negedge clk);
    chk("seq_shift", {bus.alu_req, bus.alu_cmd, bus.alu_op1, bus.alu_op2}, {1'b1, 3'b010, 16'hFFFF, 16'd1});
    @(negedge clk);
    chk("seq_eval2", {bus.alu_req, bus.done}, 32'd0);
    @(negedge clk);
    chk("seq_done", {bus.done, bus.busy}, 32'd3);
    @(negedge clk);
    chk("seq_res", {15'd0, bus.ovf, bus.result}, 32'h0000FFFF);
    bus.op_a  = 16'd3;
    bus.op_b  = 16'd5;
    bus.start = 1'b1;
    @(negedge clk);
    bus.op_a = 16'd7;
    bus.op_b = 16'd9;
    lat = 1;
    while (!bus.done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("ign_lat", lat, 10);
    @(negedge clk);
    bus.start = 1'b0;
    chk("ign_res", {15'd0, bus.ovf, bus.result}, 32'h0000000F);
    chk("ign_idle", {31'd0, bus.busy}, 32'd0);
    bus.op_a  = 16'd3;
    bus.op_b  = 16'd1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("abort_in_add", {31'd0, bus.alu_req}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_req", {31'd0, bus.alu_req}, 32'd0);
    n = 0;
    repeat (6) begin
      @(negedge clk);
      n += int'(bus.done);
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      n += int'(bus.done);
    end
    chk("abort_no_done", n, 0);
    chk("abort_cleared", {15'd0, bus.ovf, bus.result}, 32'd0);
    check_op("after_rst", 16'd6, 16'd7);
    for (int i = 0; i < 25; i++) begin
      a = 16'($urandom);
      b = (i % 3 == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      check_op($sformatf("rnd%0d", i), a, b);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
